// File: rtl/agc_timing_pkg.sv
// Shared AGC timing constants and stage-number helpers for the A1 scaler.
package agc_timing_pkg;

    localparam int STAGES_DEF     = 16;
    localparam int FAIL_LIMIT_DEF = 256;

    // Scaler stage FSn lives at bus bit n-2 (FS02 is bit 0).
    function automatic int stage_idx(input int n);
        return n - 2;
    endfunction

endpackage

// File: rtl/a1_scaler_wdog.sv
// Scaler watchdog: counts SIM_CLK cycles since the last FS01 rise and
// raises the registered alarm once the gap reaches FAIL_LIMIT.
module a1_scaler_wdog #(
    parameter int FAIL_LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rise,
    output logic alarm
);

    localparam int WDC_W = $clog2(FAIL_LIMIT + 1);
    localparam logic [WDC_W-1:0] LIMIT = WDC_W'(FAIL_LIMIT);

    logic [WDC_W-1:0] wdc;

    // Alarm looks at the gap count before this edge, so it trails the
    // saturation by one cycle and clears one cycle after a new rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdc   <= '0;
            alarm <= 1'b0;
        end else begin
            alarm <= (wdc == LIMIT);
            if (rise) begin
                wdc <= '0;
            end else if (wdc != LIMIT) begin
                wdc <= wdc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/a1_scaler.sv
// A1 frequency scaler: divides FS01 into FS02..FS(STAGES+1) with rise/fall
// strobes. Define SCALER_ALARM_EN to build the SCAFAL watchdog.
module a1_scaler
    import agc_timing_pkg::*;
#(
    parameter int STAGES     = STAGES_DEF,
    parameter int FAIL_LIMIT = FAIL_LIMIT_DEF
) (
    input  logic              SIM_CLK,
    input  logic              RESET_,
    input  logic              FS01,
    input  logic              GOJAM_,
    output logic [STAGES-1:0] FS,
    output logic [STAGES-1:0] FA,
    output logic [STAGES-1:0] FB,
    output logic              SCAFAL
);

    localparam int FS_MSB = stage_idx(STAGES + 1);

    logic              fs01_q;
    logic              rise;
    logic [FS_MSB:0]   cnt;
    logic [FS_MSB:0]   cnt_next;
    logic              unused_gojam;

    // The scaler free-runs through restarts; GOJAM_ is deliberately ignored.
    assign unused_gojam = GOJAM_;

    assign rise     = FS01 & ~fs01_q;
    assign cnt_next = cnt + 1'b1;
    assign FS       = cnt;

    // fs01_q resets high so an FS01 already high at release is not a rise.
    always_ff @(posedge SIM_CLK or negedge RESET_) begin
        if (!RESET_) begin
            fs01_q <= 1'b1;
            cnt    <= '0;
            FA     <= '0;
            FB     <= '0;
        end else begin
            fs01_q <= FS01;
            if (rise) begin
                cnt <= cnt_next;
                FA  <= cnt_next & ~cnt;
                FB  <= cnt & ~cnt_next;
            end else begin
                FA  <= '0;
                FB  <= '0;
            end
        end
    end

`ifdef SCALER_ALARM_EN
    a1_scaler_wdog #(
        .FAIL_LIMIT(FAIL_LIMIT)
    ) u_wdog (
        .clk   (SIM_CLK),
        .rst_n (RESET_),
        .rise  (rise),
        .alarm (SCAFAL)
    );
`else
    localparam int unused_fail_limit = FAIL_LIMIT;
    assign SCAFAL = 1'b0;
`endif

endmodule
